// File: rtl/writeback_stage_pipeline_pkg.sv
// Shared write-back encodings and datapath widths for the WB stage.
package writeback_stage_pipeline_pkg;

  localparam int DATA_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_e;

  function automatic logic is_half(input logic [2:0] t);
    return (t == LD_LH) || (t == LD_LHU);
  endfunction

  function automatic logic is_byte(input logic [2:0] t);
    return (t == LD_LB) || (t == LD_LBU);
  endfunction

endpackage

// File: rtl/writeback_stage_pipeline_load_extend.sv
// Extracts and sign/zero-extends load data from an aligned word; flags misaligned accesses.
module load_extend
  import writeback_stage_pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_LEN
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr_lo)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = raw;
    case (load_type)
      LD_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = raw;
    endcase
  end

  // Unlisted encodings behave as LW, so they need full word alignment.
  always_comb begin
    misalign = 1'b0;
    if (is_half(load_type))
      misalign = addr_lo[0];
    else if (!is_byte(load_type))
      misalign = (addr_lo != 2'd0);
  end

endmodule

// File: rtl/writeback_stage_pipeline.sv
// MEM/WB pipeline register, register-file write port, same-cycle read bypass and retire counter.
module writeback_stage_pipeline
  import writeback_stage_pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int ADDR_W = REG_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_we,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic [ADDR_W-1:0] id_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic              wb_valid,
  output logic              wb_misalign,
  output logic [31:0]       retire_cnt
);

  logic              valid_q;
  logic              reg_we_q;
  logic [ADDR_W-1:0] rd_q;
  wb_sel_e           sel_q;
  logic [2:0]        load_type_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] load_q;
  logic [DATA_W-1:0] pc4_q;
  logic [31:0]       retire_q;

  logic [DATA_W-1:0] load_ext;
  logic              load_misalign;
  logic              misalign;
  logic              retire;

  // A flush only kills valid; the payload fields are irrelevant once valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      rd_q        <= '0;
      sel_q       <= WB_SEL_ALU;
      load_type_q <= '0;
      addr_lo_q   <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      pc4_q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= mem_valid;
      reg_we_q    <= mem_reg_we;
      rd_q        <= mem_rd;
      sel_q       <= wb_sel_e'(mem_wb_sel);
      load_type_q <= mem_load_type;
      addr_lo_q   <= mem_addr_lo;
      alu_q       <= mem_alu_result;
      load_q      <= mem_load_data;
      pc4_q       <= mem_pc_plus4;
    end
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .raw       (load_q),
    .addr_lo   (addr_lo_q),
    .load_type (load_type_q),
    .data      (load_ext),
    .misalign  (load_misalign)
  );

  assign misalign = valid_q && (sel_q == WB_SEL_LOAD) && load_misalign;

  always_comb begin
    rf_wdata = alu_q;
    case (sel_q)
      WB_SEL_LOAD: rf_wdata = load_ext;
      WB_SEL_PC4:  rf_wdata = pc4_q;
      default:     rf_wdata = alu_q;
    endcase
  end

  assign rf_we    = valid_q && reg_we_q && (rd_q != '0) && !misalign;
  assign rf_waddr = rd_q;

  // The register file commits at the next edge, so ID must see this cycle's write here.
  always_comb begin
    id_rdata1 = rf_rdata1;
    id_rdata2 = rf_rdata2;
    if (rf_we && (rf_waddr == id_raddr1) && (id_raddr1 != '0))
      id_rdata1 = rf_wdata;
    if (rf_we && (rf_waddr == id_raddr2) && (id_raddr2 != '0))
      id_rdata2 = rf_wdata;
  end

  // Counting on the edge an instruction leaves WB makes a stalled one count exactly once.
  assign retire = valid_q && !stall && !misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_q <= '0;
    else if (retire)
      retire_q <= retire_q + 32'd1;
  end

  assign wb_valid    = valid_q;
  assign wb_misalign = misalign;
  assign retire_cnt  = retire_q;

endmodule
